// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, runs the memory read
// handshake and presents fetched words to the processing unit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        address_latch_trigger,
    output logic        ir_latch_trigger,
    output logic        pc_increment_trigger,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [31:0] PC_INIT = RESET_PC & ~32'd3;
    localparam logic [7:0]  TO_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nx;
    logic [31:0] target;
    logic        pending;
    logic        pending_nx;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nx;
    logic        capture;

    assign target = branch_target & ~32'd3;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        pending_nx  = pending;
        wait_cnt_nx = wait_cnt;
        capture     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (branch_valid) fetch_pc_nx = target;
                if (enable) state_nx = S_ADDR;
            end
            S_ADDR: begin
                if (branch_valid) begin
                    fetch_pc_nx = target;
                    pending_nx  = 1'b1;
                end
                wait_cnt_nx = 8'd0;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_nx = wait_cnt + 8'd1;
                if (branch_valid) fetch_pc_nx = target;
                if (mem_ready) begin
                    if (pending || branch_valid) begin
                        // superseded read: drop the data and refetch
                        pending_nx = 1'b0;
                        state_nx   = S_ADDR;
                    end else begin
                        capture     = 1'b1;
                        fetch_pc_nx = fetch_pc + 32'd4;
                        state_nx    = S_HOLD;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    pending_nx = 1'b0;
                    state_nx   = S_FAULT;
                end else if (branch_valid) begin
                    pending_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_valid) begin
                    fetch_pc_nx = target;
                    state_nx    = S_ADDR;
                end else if (instr_ready) begin
                    state_nx = enable ? S_ADDR : S_IDLE;
                end
            end
            S_FAULT: begin
                state_nx = S_FAULT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= PC_INIT;
            pending  <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            pending  <= pending_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // all outputs registered from next-state so they line up with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr              <= 32'd0;
            mem_req               <= 1'b0;
            instr                 <= 32'd0;
            instr_pc              <= 32'd0;
            instr_valid           <= 1'b0;
            address_latch_trigger <= 1'b0;
            ir_latch_trigger      <= 1'b0;
            pc_increment_trigger  <= 1'b0;
            fetch_fault           <= 1'b0;
        end else begin
            if (state_nx == S_ADDR) mem_addr <= fetch_pc_nx;
            if (capture) begin
                instr    <= mem_rdata;
                instr_pc <= mem_addr;
            end
            mem_req               <= (state_nx == S_WAIT);
            instr_valid           <= (state_nx == S_HOLD);
            address_latch_trigger <= (state_nx == S_ADDR);
            ir_latch_trigger      <= capture;
            pc_increment_trigger  <= capture;
            fetch_fault           <= (state_nx == S_FAULT);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: timing vectors, corner sequences and a
// randomized run against a PC/handover scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic        instr_ready = 1'b0;
    logic        force_en = 1'b0;
    logic [31:0] force_data = 32'd0;

    logic [31:0] mem_addr, instr, instr_pc;
    logic        mem_req, instr_valid, alt, irt, pct, fetch_fault;
    logic [31:0] mem_addr2, instr2, instr_pc2;
    logic        mem_req2, instr_valid2, alt2, irt2, pct2, fetch_fault2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata = force_en ? force_data : mem_word(mem_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .address_latch_trigger(alt), .ir_latch_trigger(irt),
        .pc_increment_trigger(pct), .fetch_fault(fetch_fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .WAIT_TIMEOUT(15)) dut2 (
        .clk(clk), .reset(reset), .enable(enable),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .mem_addr(mem_addr2), .mem_req(mem_req2), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .address_latch_trigger(alt2), .ir_latch_trigger(irt2),
        .pc_increment_trigger(pct2), .fetch_fault(fetch_fault2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        enable = 1'b0;
        branch_valid = 1'b0;
        mem_ready = 1'b0;
        instr_ready = 1'b0;
        force_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step;
            n++;
        end
        chk(name, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_flags"},
            {25'd0, mem_req, instr_valid, alt, irt, pct, fetch_fault, mem_req2},
            32'd0);
        chk({name, "_maddr"}, mem_addr, 32'd0);
        chk({name, "_instr"}, instr, 32'd0);
        chk({name, "_ipc"}, instr_pc, 32'd0);
        chk({name, "_ipc2"}, instr_pc2, 32'd0);
    endtask

    typedef struct packed {
        logic        en;
        logic        mrdy;
        logic        irdy;
        logic [4:0]  flags;
        logic [31:0] maddr;
        logic [31:0] ipc;
        logic [31:0] ipc2;
        logic        has_instr;
    } vec_t;

    function automatic vec_t mk(input logic irdy, input logic [4:0] flags,
                                input logic [31:0] maddr, input logic [31:0] ipc,
                                input logic [31:0] ipc2, input logic has_instr);
        vec_t v;
        v.en = 1'b1;
        v.mrdy = 1'b1;
        v.irdy = irdy;
        v.flags = flags;
        v.maddr = maddr;
        v.ipc = ipc;
        v.ipc2 = ipc2;
        v.has_instr = has_instr;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin : main
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        prev_valid;
        logic        b, ir, mr;
        int          wait_ctr;
        int          consumed;

        // flags = {req, alt, irt, pct, valid}
        tbl[0]  = mk(1, 5'b01000, 32'd0,  32'd0, 32'd0,          0);
        tbl[1]  = mk(1, 5'b10000, 32'd0,  32'd0, 32'd0,          0);
        tbl[2]  = mk(1, 5'b00111, 32'd0,  32'd0, 32'hFFFF_FFFC,  1);
        tbl[3]  = mk(1, 5'b01000, 32'd4,  32'd0, 32'hFFFF_FFFC,  1);
        tbl[4]  = mk(1, 5'b10000, 32'd4,  32'd0, 32'hFFFF_FFFC,  1);
        tbl[5]  = mk(1, 5'b00111, 32'd4,  32'd4, 32'h0000_0000,  1);
        tbl[6]  = mk(1, 5'b01000, 32'd8,  32'd4, 32'h0000_0000,  1);
        tbl[7]  = mk(1, 5'b10000, 32'd8,  32'd4, 32'h0000_0000,  1);
        tbl[8]  = mk(1, 5'b00111, 32'd8,  32'd8, 32'h0000_0004,  1);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(0, 5'b00001, 32'd8, 32'd8, 32'h0000_0004, 1);
        tbl[14] = mk(1, 5'b01000, 32'd12, 32'd8, 32'h0000_0004, 1);

        do_reset;
        chk_all_zero("reset");

        for (int i = 0; i < 15; i++) begin
            enable = tbl[i].en;
            mem_ready = tbl[i].mrdy;
            instr_ready = tbl[i].irdy;
            step;
            chk($sformatf("vec%0d_flags", i),
                {27'd0, mem_req, alt, irt, pct, instr_valid},
                {27'd0, tbl[i].flags});
            chk($sformatf("vec%0d_maddr", i), mem_addr, tbl[i].maddr);
            chk($sformatf("vec%0d_ipc", i), instr_pc, tbl[i].ipc);
            chk($sformatf("vec%0d_ipc2", i), instr_pc2, tbl[i].ipc2);
            if (tbl[i].has_instr)
                chk($sformatf("vec%0d_instr", i), instr, mem_word(tbl[i].ipc));
        end

        // redirect during WAIT: in-flight data must be discarded
        mem_ready = 1'b0;
        instr_ready = 1'b0;
        step;
        chk("br_wait_req", {31'd0, mem_req}, 32'd1);
        branch_valid = 1'b1;
        branch_target = 32'h0000_1003;
        step;
        branch_valid = 1'b0;
        step;
        force_en = 1'b1;
        force_data = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
        step;
        force_en = 1'b0;
        chk("br_discard_flags", {28'd0, alt, irt, pct, instr_valid}, 32'b1000);
        chk("br_maddr", mem_addr, 32'h0000_1000);
        chk("br_instr_kept", instr, mem_word(32'd8));
        instr_ready = 1'b1;
        step;
        step;
        chk("br_valid", {31'd0, instr_valid}, 32'd1);
        chk("br_ipc", instr_pc, 32'h0000_1000);
        chk("br_instr", instr, mem_word(32'h0000_1000));

        // memory never answers: timeout into sticky FAULT
        mem_ready = 1'b0;
        step;
        step;
        chk("to_enter", {30'd0, mem_req, fetch_fault}, 32'b10);
        for (int k = 1; k < 15; k++) begin
            step;
            chk($sformatf("to_wait%0d", k), {30'd0, mem_req, fetch_fault}, 32'b10);
        end
        step;
        chk("to_fault", {30'd0, mem_req, fetch_fault}, 32'b01);
        branch_valid = 1'b1;
        branch_target = 32'h0000_0040;
        step;
        branch_valid = 1'b0;
        repeat (3) step;
        chk("fault_sticky",
            {27'd0, mem_req, alt, instr_valid, irt, fetch_fault}, 32'b00001);
        chk("fault_maddr", mem_addr, 32'h0000_1004);

        // asynchronous reset in the middle of a WAIT
        do_reset;
        enable = 1'b1;
        mem_ready = 1'b1;
        instr_ready = 1'b1;
        wait_valid("rst_first_valid");
        mem_ready = 1'b0;
        step;
        step;
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        chk("rst_pre_maddr", mem_addr, 32'd4);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        reset = 1'b0;
        mem_ready = 1'b1;
        wait_valid("rst_restart_valid");
        chk("rst_restart_ipc", instr_pc, 32'd0);
        chk("rst_restart_ipc2", instr_pc2, 32'hFFFF_FFFC);

        // randomized run against the handover scoreboard
        do_reset;
        exp_pc = 32'd0;
        prev_valid = 1'b0;
        wait_ctr = 0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_req_alt", {31'd0, mem_req & alt}, 32'd0);
            chk("rnd_irt_rise", {31'd0, irt}, {31'd0, instr_valid & ~prev_valid});
            chk("rnd_pct_irt", {31'd0, pct}, {31'd0, irt});
            prev_valid = instr_valid;
            b = ($urandom_range(15) == 0);
            tgt = $urandom;
            ir = !b && ($urandom_range(1) == 1);
            mr = mem_req && (wait_ctr >= 8 || $urandom_range(2) == 0);
            wait_ctr = (mem_req && !mr) ? wait_ctr + 1 : 0;
            if (instr_valid && ir) begin
                consumed++;
                chk("rnd_pc", instr_pc, exp_pc);
                chk("rnd_data", instr, mem_word(instr_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (b) exp_pc = tgt & ~32'd3;
            enable = ($urandom_range(7) != 0);
            branch_valid = b;
            branch_target = tgt;
            instr_ready = ir;
            mem_ready = mr;
            step;
        end
        chk("rnd_no_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rnd_progress", {31'd0, consumed > 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer sitting directly upstream of the processing unit. It owns the fetch program counter and runs a request/ready read handshake with instruction memory. It presents each fetched word to the processing unit through a valid/ready handshake and drives the unit's `address_latch_trigger`, `ir_latch_trigger` and `pc_increment_trigger` strobes. It also handles branch redirects and memory-wait timeouts.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset; low 2 bits forced to 0
- `WAIT_TIMEOUT`, 15, max cycles in WAIT without `mem_ready` before fault; legal range 1..255

- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `enable`  in  1  permits starting new fetches
- `branch_valid`  in  1  one-cycle redirect request
- `branch_target`  in  32  redirect address; low 2 bits ignored
- `mem_addr`  out  32  read address to instruction memory
- `mem_req`  out  1  read request, held until `mem_ready`
- `mem_ready`  in  1  memory completes read this cycle
- `mem_rdata`  in  32  read data, valid when `mem_ready`=1
- `instr`  out  32  fetched instruction word
- `instr_pc`  out  32  address `instr` was fetched from
- `instr_valid`  out  1  `instr` is presentable
- `instr_ready`  in  1  processing unit accepts `instr`
- `address_latch_trigger`  out  1  one-cycle pulse: `mem_addr` updated
- `ir_latch_trigger`  out  1  one-cycle pulse: `instr` updated
- `pc_increment_trigger`  out  1  one-cycle pulse: fetch PC advanced
- `fetch_fault`  out  1  sticky timeout flag

## Operation
- States: IDLE, ADDR, WAIT, HOLD, FAULT. On reset, the block is in IDLE, `fetch_pc`=RESET_PC&~3, and every output is 0.
- IDLE:
  - `enable`=1 -> ADDR.
- ADDR, one cycle:
  - `mem_addr`<=`fetch_pc`.
  - Pulse `address_latch_trigger`.
  - -> WAIT.
- WAIT:
  - `mem_req`=1 throughout WAIT.
  - Wait counter clears on entry and increments each cycle.
  - On `mem_ready`=1 with no pending redirect: `instr`<=`mem_rdata`, `instr_pc`<=`mem_addr`, `fetch_pc`<=`fetch_pc`+4.
  - In that same edge, pulse `ir_latch_trigger` and `pc_increment_trigger`, then -> HOLD.
  - On `mem_ready`=1 with a redirect pending: discard data, assert no pulses, clear pending, -> ADDR.
  - If the counter reaches WAIT_TIMEOUT with no `mem_ready`: drop `mem_req`, set `fetch_fault`, -> FAULT.
- HOLD:
  - `instr_valid`=1.
  - On `instr_ready`=1: -> ADDR if `enable`, else IDLE.
  - `instr`/`instr_pc` stay stable while `instr_valid`=1 and `instr_ready`=0.
- FAULT:
  - Terminal; all strobes 0 and `mem_req`=0.
  - Only `reset` exits.
  - `branch_valid` is ignored.
- Redirect (`branch_valid`=1), in any state except FAULT:
  - `fetch_pc`<=`branch_target`&~3.
  - In HOLD: drop `instr_valid` next cycle, do not hand over, -> ADDR.
  - In WAIT: set pending-redirect; the in-flight read must still complete.
  - In ADDR: the issued address is superseded; the block still goes to WAIT and treats the access as redirected.
  - In IDLE: only `fetch_pc` updates.
- Redirect and `instr_ready` in the same HOLD cycle: the redirect wins and the instruction is not consumed. The processing unit never asserts both.
- Redirect and `mem_ready` in the same WAIT cycle: the data is discarded.
- Arithmetic: `fetch_pc` is a 32-bit modulo counter; 32'hFFFF_FFFC+4 = 32'h0000_0000 with no flag.
- `enable` falling: no effect on an in-flight fetch. It is sampled only on leaving IDLE and HOLD.

## Timing
- Best case (`mem_ready` in the first WAIT cycle, `instr_ready` high): ADDR at N, WAIT at N+1, `instr_valid` high at N+2, next ADDR at N+3. Steady state is 3 cycles per instruction.
- Latency from entering ADDR to `instr_valid` = 2 + (WAIT cycles − 1).
- `ir_latch_trigger` and `pc_increment_trigger` are high in the first HOLD cycle only, coincident with `instr_valid` rising.
- `address_latch_trigger` is high for exactly the single ADDR cycle, coincident with the new `mem_addr`.
- `mem_req` is registered and never asserted in the same cycle as `address_latch_trigger`.
- Timeout: with no ready, `fetch_fault` rises WAIT_TIMEOUT cycles after WAIT entry, and `mem_req` falls in that same cycle.
- Reset mid-operation: outputs go to 0 asynchronously and `mem_req` drops at once. Any outstanding memory read is abandoned.

## Test plan
- Reset, then `enable`=1, memory ready in 1 cycle, `instr_ready`=1 -> `instr_pc` sequence 0,4,8 at 3-cycle spacing; each trigger pulses once per instruction.
- `instr_ready` held low 5 cycles in HOLD -> `instr` and `instr_pc` constant, no new `mem_req`, no extra triggers.
- `branch_valid` with target 32'h0000_1003 during WAIT, `mem_ready` 2 cycles later with 32'hDEADBEEF -> data never presented; next `mem_addr`=32'h0000_1000.
- RESET_PC=32'hFFFF_FFFC -> first `instr_pc`=32'hFFFF_FFFC, second =32'h0000_0000.
- `mem_ready` never asserted, WAIT_TIMEOUT=15 -> `fetch_fault`=1 after 15 WAIT cycles; `mem_req`=0 and the block stays in FAULT despite `branch_valid`.
- Assert `reset` during WAIT -> all outputs 0 before the next clock edge; fetching restarts from RESET_PC.
